// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit driving the datapath.
// Define CTRL_SINGLE_STEP_EN to add a step input that gates each fetch.
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic [NREGS-1:0] r_in,
  output logic [NREGS-1:0] r_out,
  output logic             pc_out,
  output logic             pc_in,
  output logic             pc_increment,
  output logic             MARin,
  output logic             read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             RYin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic [OPW-1:0]   op_code,
  output logic             halted
);

  typedef enum logic [2:0] {
    T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  localparam logic [NREGS-1:0] ONE = NREGS'(1);

  state_t     state;
  logic [4:0] op_q;
  logic [3:0] ra_q;
  logic [3:0] rc_q;
  logic       go;
  logic       to_t0;

  logic [4:0] opc;
  logic [3:0] rb;
  logic       unused_ir;

  assign opc       = ir[31:27];
  assign rb        = ir[22:19];
  assign unused_ir = ^ir[14:0];

  function automatic logic is_md(input logic [4:0] op);
    return (op == 5'b01111) || (op == 5'b10000);
  endfunction

  function automatic logic is_bin(input logic [4:0] op);
    return (op <= 5'b01000) || is_md(op);
  endfunction

  function automatic logic is_un(input logic [4:0] op);
    return (op == 5'b10010) || (op == 5'b10011);
  endfunction

  function automatic logic is_halt(input logic [4:0] op);
    return op == 5'b11011;
  endfunction

`ifdef CTRL_SINGLE_STEP_EN
  logic step_q;
  logic step_pend;
  logic step_rise;

  assign step_rise = step & ~step_q;
  assign go        = run & (step_pend | step_rise);

  // One rising edge of step buys exactly one fetch.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q <= step;
      if (to_t0 && go)
        step_pend <= 1'b0;
      else if (step_rise)
        step_pend <= 1'b1;
    end
  end
`else
  assign go = run;
`endif

  // run is sampled on each edge that lands in T0; an armed T0 must fetch.
  always_comb begin
    to_t0 = 1'b0;
    unique case (state)
      T0:      to_t0 = !pc_out;
      T3:      to_t0 = !is_bin(op_q) && !is_un(op_q)
                       && !is_halt(op_q);
      T5:      to_t0 = !is_md(op_q);
      T6:      to_t0 = 1'b1;
      default: to_t0 = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= T0;
      op_q         <= '0;
      ra_q         <= '0;
      rc_q         <= '0;
      r_in         <= '0;
      r_out        <= '0;
      pc_out       <= 1'b0;
      pc_in        <= 1'b0;
      pc_increment <= 1'b0;
      MARin        <= 1'b0;
      read         <= 1'b0;
      MDRin        <= 1'b0;
      MDRout       <= 1'b0;
      IRin         <= 1'b0;
      RYin         <= 1'b0;
      Zlowin       <= 1'b0;
      Zhighin      <= 1'b0;
      Zlowout      <= 1'b0;
      Zhighout     <= 1'b0;
      HIin         <= 1'b0;
      LOin         <= 1'b0;
      op_code      <= '0;
      halted       <= 1'b0;
    end else begin
      r_in         <= '0;
      r_out        <= '0;
      pc_out       <= 1'b0;
      pc_in        <= 1'b0;
      pc_increment <= 1'b0;
      MARin        <= 1'b0;
      read         <= 1'b0;
      MDRin        <= 1'b0;
      MDRout       <= 1'b0;
      IRin         <= 1'b0;
      RYin         <= 1'b0;
      Zlowin       <= 1'b0;
      Zhighin      <= 1'b0;
      Zlowout      <= 1'b0;
      Zhighout     <= 1'b0;
      HIin         <= 1'b0;
      LOin         <= 1'b0;
      op_code      <= '0;
      halted       <= 1'b0;

      if (to_t0) begin
        state <= T0;
        if (go) begin
          pc_out       <= 1'b1;
          pc_increment <= 1'b1;
          MARin        <= 1'b1;
          Zlowin       <= 1'b1;
          Zhighin      <= 1'b1;
        end
      end else begin
        unique case (state)
          T0: begin
            state   <= T1;
            Zlowout <= 1'b1;
            pc_in   <= 1'b1;
            read    <= 1'b1;
            MDRin   <= 1'b1;
          end
          T1: begin
            if (mem_ready) begin
              state  <= T2;
              MDRout <= 1'b1;
              IRin   <= 1'b1;
            end else begin
              read  <= 1'b1;
              MDRin <= 1'b1;
            end
          end
          // ir must hold the new instruction by the end of T2.
          T2: begin
            state <= T3;
            op_q  <= opc;
            ra_q  <= ir[26:23];
            rc_q  <= ir[18:15];
            if (is_bin(opc)) begin
              r_out <= ONE << rb;
              RYin  <= 1'b1;
            end else if (is_un(opc)) begin
              r_out   <= ONE << rb;
              Zlowin  <= 1'b1;
              Zhighin <= 1'b1;
              op_code <= OPW'(opc);
            end
          end
          T3: begin
            if (is_bin(op_q)) begin
              state   <= T4;
              r_out   <= ONE << rc_q;
              Zlowin  <= 1'b1;
              Zhighin <= 1'b1;
              op_code <= OPW'(op_q);
            end else if (is_un(op_q)) begin
              state   <= T5;
              Zlowout <= 1'b1;
              r_in    <= ONE << ra_q;
            end else begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
          T4: begin
            state   <= T5;
            Zlowout <= 1'b1;
            if (is_md(op_q))
              LOin <= 1'b1;
            else
              r_in <= ONE << ra_q;
          end
          T5: begin
            state    <= T6;
            Zhighout <= 1'b1;
            HIin     <= 1'b1;
          end
          T6: state <= T0;
          HALT: begin
            state  <= HALT;
            halted <= 1'b1;
          end
          default: state <= T0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed + random instructions against a
// cycle-trace model built from instruction class and memory wait count.
`timescale 1ns/1ps
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step;
`endif
  logic [15:0] r_in, r_out;
  logic pc_out, pc_in, pc_increment, MARin, read, MDRin, MDRout, IRin;
  logic RYin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, halted;
  logic [4:0]  op_code;

  always #5 clk = ~clk;

  control_sequencer #(.NREGS(16), .OPW(5)) dut (
    .clk(clk), .clr(clr), .run(run),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .ir(ir), .mem_ready(mem_ready),
    .r_in(r_in), .r_out(r_out),
    .pc_out(pc_out), .pc_in(pc_in), .pc_increment(pc_increment),
    .MARin(MARin), .read(read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .RYin(RYin), .Zlowin(Zlowin), .Zhighin(Zhighin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .op_code(op_code), .halted(halted)
  );

  typedef struct packed {
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic pc_out, pc_in, pc_inc, mar_in, read, mdr_in, mdr_out, ir_in;
    logic ry_in, zl_in, zh_in, zl_out, zh_out, hi_in, lo_in;
    logic [4:0] op;
    logic halted;
  } ov_t;

  typedef struct {
    ov_t  o;
    logic mr;
  } cyc_t;

  cyc_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  bit   auto_step = 1'b1;

  function automatic ov_t observe();
    ov_t v;
    v = '{r_in, r_out, pc_out, pc_in, pc_increment, MARin, read, MDRin,
          MDRout, IRin, RYin, Zlowin, Zhighin, Zlowout, Zhighout, HIin,
          LOin, op_code, halted};
    return v;
  endfunction

  // 0 binary, 1 mul/div, 2 unary, 3 nop/undefined, 4 halt
  function automatic int kind_of(input logic [4:0] op);
    if (op <= 5'd8) return 0;
    if (op == 5'd15 || op == 5'd16) return 1;
    if (op == 5'd18 || op == 5'd19) return 2;
    if (op == 5'd27) return 4;
    return 3;
  endfunction

  function automatic void push(input ov_t o, input logic mr);
    cyc_t c;
    c.o  = o;
    c.mr = mr;
    exp_q.push_back(c);
  endfunction

  function automatic void build(input logic [31:0] i, input int w);
    ov_t o;
    int  k = kind_of(i[31:27]);
    logic [3:0] ra = i[26:23];
    logic [3:0] rb = i[22:19];
    logic [3:0] rc = i[18:15];
    exp_q.delete();
    o = '0; o.pc_out = 1; o.pc_inc = 1; o.mar_in = 1;
    o.zl_in = 1; o.zh_in = 1;
    push(o, 1'b0);
    o = '0; o.zl_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1;
    push(o, w == 0);
    for (int j = 1; j <= w; j++) begin
      o = '0; o.read = 1; o.mdr_in = 1;
      push(o, j == w);
    end
    o = '0; o.mdr_out = 1; o.ir_in = 1;
    push(o, 1'b0);
    o = '0;
    if (k <= 1) begin
      o.r_out = 16'h1 << rb; o.ry_in = 1;
    end else if (k == 2) begin
      o.r_out = 16'h1 << rb; o.zl_in = 1; o.zh_in = 1; o.op = i[31:27];
    end
    push(o, 1'b0);
    if (k <= 1) begin
      o = '0; o.r_out = 16'h1 << rc; o.zl_in = 1; o.zh_in = 1;
      o.op = i[31:27];
      push(o, 1'b0);
    end
    if (k <= 2) begin
      o = '0; o.zl_out = 1;
      if (k == 1) o.lo_in = 1;
      else o.r_in = 16'h1 << ra;
      push(o, 1'b0);
    end
    if (k == 1) begin
      o = '0; o.zh_out = 1; o.hi_in = 1;
      push(o, 1'b0);
    end
  endfunction

  task automatic chk(input string tag, input ov_t want);
    ov_t got;
    got = observe();
    vectors++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic run_instr(input logic [31:0] i, input int w,
                           input int ncyc, input logic last_run);
    build(i, w);
    ir = i;
    for (int c = 0; c < exp_q.size() && c < ncyc; c++) begin
      @(negedge clk);
      chk($sformatf("op%02h_c%0d", i[31:27], c), exp_q[c].o);
      mem_ready = exp_q[c].mr;
`ifdef CTRL_SINGLE_STEP_EN
      if (auto_step) step = (c == 1);
`endif
      if (c == exp_q.size() - 1) run = last_run;
    end
  endtask

  task automatic release_clr();
    clr = 1'b1;
    run = 1'b1;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input int ra,
                                     input int rb, input int rc);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'h0};
  endfunction

  initial begin
    ov_t zero;
    ov_t hlt;
    logic [4:0] op;
    zero = '0;
    hlt = '0; hlt.halted = 1'b1;
    clr = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = '0;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset", zero);
    release_clr();

    run_instr(32'h41000000, 0, 99, 1'b1);
    run_instr(mk(5'd0, 9, 4, 11), 3, 99, 1'b1);
    run_instr(mk(5'd15, 5, 3, 7), 0, 99, 1'b1);
    run_instr(mk(5'd16, 0, 15, 1), 1, 99, 1'b1);
    run_instr(mk(5'd19, 14, 6, 2), 0, 99, 1'b1);
    run_instr(mk(5'd26, 1, 2, 3), 2, 99, 1'b1);

    for (int n = 0; n < 40; n++) begin
      do op = 5'($urandom_range(0, 31)); while (op == 5'd27);
      run_instr(mk(op, $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15)),
                $urandom_range(0, 3), 99, n != 39);
    end
    repeat (3) begin
      @(negedge clk);
      chk("idle_run0", zero);
    end

    run = 1'b1;
    run_instr(mk(5'd1, 3, 4, 5), 0, 5, 1'b1);
    clr = 1'b0;
    #1 chk("clr_async", zero);
    @(negedge clk); chk("clr_hold1", zero);
    @(negedge clk); chk("clr_hold2", zero);
    release_clr();
    run_instr(mk(5'd7, 12, 1, 8), 0, 99, 1'b1);

    run_instr(mk(5'd27, 0, 0, 0), 0, 99, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("halted", hlt);
    end
    clr = 1'b0;
    #1 chk("halt_clr", zero);
    @(negedge clk);
    release_clr();
    run_instr(mk(5'd26, 0, 0, 0), 0, 99, 1'b0);
    @(negedge clk); chk("post_halt_idle", zero);

`ifdef CTRL_SINGLE_STEP_EN
    auto_step = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    release_clr();
    run_instr(32'h41000000, 0, 99, 1'b1);
    repeat (14) begin
      @(negedge clk);
      chk("step_held", zero);
    end
    step = 1'b0;
    @(negedge clk); chk("step_low", zero);
    step = 1'b1;
    run_instr(mk(5'd18, 6, 2, 0), 1, 99, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("step_held2", zero);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
